// File: rtl/adc_disp_pkg.sv
// Shared constants, FSM state type and double-dabble step
// for the ADC display sequencer.
package adc_disp_pkg;

  localparam int ADC_W     = 12;
  localparam int BCD_W     = 16;
  localparam int SHIFT_CNT = 12;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE,
    S_DWELL
  } seq_state_t;

  function automatic logic [BCD_W-1:0] dabble_step(
    input logic [BCD_W-1:0] b,
    input logic             in_bit
  );
    logic [BCD_W-1:0] a;
    a = b;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (a[4*i +: 4] >= 4'd5)
        a[4*i +: 4] = a[4*i +: 4] + 4'd3;
    end
    return {a[BCD_W-2:0], in_bit};
  endfunction

endpackage

// File: rtl/adc_display_sequencer_bcd_shift_converter.sv
// Iterative 12-bit binary to 4-digit BCD converter.
// The first shift happens on the start edge; done pulses with the final result.
module bcd_shift_converter
  import adc_disp_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [ADC_W-1:0] bin,
  output logic [BCD_W-1:0] bcd,
  output logic             done
);

  logic [ADC_W-1:0] bin_q;
  logic [BCD_W-1:0] bcd_q;
  logic [3:0]       cnt_q;
  logic             run_q;
  logic             done_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else if (start) begin
      bcd_q  <= dabble_step('0, bin[ADC_W-1]);
      bin_q  <= {bin[ADC_W-2:0], 1'b0};
      cnt_q  <= 4'd1;
      run_q  <= 1'b1;
      done_q <= 1'b0;
    end else if (run_q) begin
      bcd_q <= dabble_step(bcd_q, bin_q[ADC_W-1]);
      bin_q <= {bin_q[ADC_W-2:0], 1'b0};
      cnt_q <= cnt_q + 4'd1;
      if (cnt_q == 4'(SHIFT_CNT - 1)) begin
        run_q  <= 1'b0;
        done_q <= 1'b1;
      end
    end else begin
      done_q <= 1'b0;
    end
  end

  assign bcd  = bcd_q;
  assign done = done_q;

endmodule

// File: rtl/adc_display_sequencer.sv
// Round-robin ADC-to-BCD display sequencer sharing one converter.
// Optional round argmax tracking: define ADC_SEQ_MAX_TRACK_EN.
module adc_display_sequencer
  import adc_disp_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int DWELL_CYCLES = 50_000_000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [NUM_CH*ADC_W-1:0]   adc_data,
  input  logic [NUM_CH-1:0]         adc_valid,
  output logic [BCD_W-1:0]          bcd_value,
  output logic                      bcd_valid,
  output logic [$clog2(NUM_CH)-1:0] cur_channel,
  output logic                      busy,
  output logic [$clog2(NUM_CH)-1:0] max_channel
);

  localparam int CW  = $clog2(NUM_CH);
  localparam int DCW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CW-1:0]  LAST_CH    = CW'(NUM_CH - 1);
  localparam logic [DCW-1:0] DWELL_LAST =
    DCW'((DWELL_CYCLES > 0) ? DWELL_CYCLES - 1 : 0);

  logic [NUM_CH-1:0][ADC_W-1:0] sample_q;
  logic [ADC_W-1:0] cur_sample;

  seq_state_t     state_q, state_d;
  logic [CW-1:0]  ptr_q, ptr_d, ptr_next;
  logic [DCW-1:0] dwell_q, dwell_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [CW-1:0]  chan_q, chan_d;

  logic             conv_start;
  logic [BCD_W-1:0] conv_bcd;
  logic             conv_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample_q <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (adc_valid[k])
          sample_q[k] <= adc_data[k*ADC_W +: ADC_W];
      end
    end
  end

  assign cur_sample = sample_q[ptr_q];
  assign ptr_next   = (ptr_q == LAST_CH) ? '0 : ptr_q + 1'b1;

  bcd_shift_converter u_conv (
    .clk   (clk),
    .reset (reset),
    .start (conv_start),
    .bin   (cur_sample),
    .bcd   (conv_bcd),
    .done  (conv_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      dwell_q <= '0;
      bcd_q   <= '0;
      chan_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      dwell_q <= dwell_d;
      bcd_q   <= bcd_d;
      chan_q  <= chan_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    dwell_d    = dwell_q;
    bcd_d      = bcd_q;
    chan_d     = chan_q;
    conv_start = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_LOAD;
      end
      S_LOAD: begin
        conv_start = 1'b1;
        state_d    = S_SHIFT;
      end
      S_SHIFT: begin
        // Result registered on entry so it is already visible in DONE
        if (conv_done) begin
          state_d = S_DONE;
          bcd_d   = conv_bcd;
          chan_d  = ptr_q;
        end
      end
      S_DONE: begin
        dwell_d = '0;
        if (!enable) begin
          state_d = S_IDLE;
        end else if (DWELL_CYCLES == 0) begin
          state_d = S_LOAD;
          ptr_d   = ptr_next;
        end else begin
          state_d = S_DWELL;
        end
      end
      S_DWELL: begin
        if (!enable) begin
          state_d = S_IDLE;
          dwell_d = '0;
        end else if (dwell_q == DWELL_LAST) begin
          state_d = S_LOAD;
          ptr_d   = ptr_next;
          dwell_d = '0;
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bcd_value   = bcd_q;
  assign cur_channel = chan_q;
  assign bcd_valid   = (state_q == S_DONE);
  assign busy        = (state_q == S_LOAD) ||
                       (state_q == S_SHIFT) ||
                       (state_q == S_DONE);

`ifdef ADC_SEQ_MAX_TRACK_EN
  logic [ADC_W-1:0] snap_q, run_max_q;
  logic [CW-1:0]    run_idx_q, max_q;
  logic             better;

  // Strict compare keeps the lower index on ties
  assign better = (snap_q > run_max_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_q    <= '0;
      run_max_q <= '0;
      run_idx_q <= '0;
      max_q     <= '0;
    end else begin
      if (state_q == S_LOAD)
        snap_q <= cur_sample;
      if (state_q == S_DONE) begin
        if (ptr_q == LAST_CH) begin
          max_q     <= better ? ptr_q : run_idx_q;
          run_max_q <= '0;
          run_idx_q <= '0;
        end else if (better) begin
          run_max_q <= snap_q;
          run_idx_q <= ptr_q;
        end
      end
    end
  end

  assign max_channel = max_q;
`else
  assign max_channel = '0;
`endif

endmodule

// File: doc/adc_display_sequencer.md
# adc_display_sequencer

Round-robin scheduler that shares one iterative binary-to-BCD converter among `NUM_CH` light-sensor ADC channels. For each channel it converts the latest 12-bit sample to four BCD digits, presents the digits to the seven-segment decoder stage, and holds them for a programmable dwell time before moving to the next channel. It sits between the ADC sample interface and the HEX digit decoders in the sunflower light path.

## Interface
- `NUM_CH`, default 4: number of ADC channels, 2..8.
- `DWELL_CYCLES`, default 50_000_000: display hold per channel after conversion, in clocks. 0 is legal.
- `clk`  in  1: system clock.
- `reset`  in  1: asynchronous, active-high reset.
- `enable`  in  1: run the sequencer.
- `adc_data`  in  `NUM_CH*12`: channel k occupies bits `[12k+11:12k]`.
- `adc_valid`  in  `NUM_CH`: per-channel sample strobe.
- `bcd_value`  out  16: thousands/hundreds/tens/ones nibbles `[15:12]..[3:0]`.
- `bcd_valid`  out  1: one-cycle pulse when `bcd_value` updates.
- `cur_channel`  out  `$clog2(NUM_CH)`: channel shown on `bcd_value`.
- `busy`  out  1: high from LOAD through DONE.
- `max_channel`  out  `$clog2(NUM_CH)`: brightest channel of the last complete round.

## Operation
- Sample capture is independent of the FSM. When `adc_valid[k]` is high at a clock edge, `sample[k]` is written with that channel's slice of `adc_data`.
- FSM states: IDLE, LOAD, SHIFT, DONE, DWELL.
- IDLE: `busy`=0. When `enable`=1, go to LOAD.
- LOAD (1 cycle):
  - Snapshot `sample[ptr]`. A same-cycle capture on that channel is not seen; it is picked up on the next round.
  - Pulse `start` to the converter and set `busy`=1.
- SHIFT (12 cycles): the converter runs double-dabble. Each cycle it first adds 3 to every BCD nibble ≥5, then shifts left one bit, bringing in the binary MSB.
- DONE (1 cycle):
  - `bcd_value` is set to the converter result, `cur_channel` to `ptr`, and `bcd_valid` pulses.
  - If `enable`=1, go to DWELL; otherwise go to IDLE.
- DWELL:
  - Count `DWELL_CYCLES` cycles, then set `ptr` to `(ptr+1) mod NUM_CH` and go to LOAD. With `DWELL_CYCLES`=0, DWELL is skipped and DONE goes straight to LOAD with the pointer advanced.
  - `enable`=0 during DWELL: go to IDLE immediately, clear the counter, leave `ptr` unchanged. Re-enabling reconverts the same channel.
- `enable`=0 during LOAD or SHIFT: the conversion completes, DONE pulses normally, then the FSM goes to IDLE.
- Arithmetic: a 12-bit input (maximum 4095) always fits in four BCD digits, with no overflow. The converter result equals the decimal value of the snapshot.
- Reset values: state IDLE, `ptr`=0, all `sample` registers 0, `bcd_value`=16'h0000, `bcd_valid`=0, `cur_channel`=0, `busy`=0, `max_channel`=0.
- Reset asserted mid-operation aborts the conversion, and outputs take their reset values asynchronously. No `bcd_valid` pulse is emitted for the aborted conversion.

## Timing
- LOAD is cycle 0, SHIFT occupies cycles 1–12, and DONE is cycle 13, where `bcd_valid` is high.
- With continuous `enable`, the next LOAD falls on cycle `14+DWELL_CYCLES`, so the channel period is `14+DWELL_CYCLES` clocks.
- A `sample` update is visible to a LOAD one cycle after the `adc_valid` edge.
- `bcd_value` and `cur_channel` change only in DONE or on reset.

## Configuration
- `ADC_SEQ_MAX_TRACK_EN` defined:
  - Each DONE compares the snapshot against the running round maximum; on a tie, the lower index wins.
  - The DONE for channel `NUM_CH-1` loads `max_channel` with the argmax and clears the running maximum.
  - A round interrupted by IDLE continues tracking when re-enabled.
- `ADC_SEQ_MAX_TRACK_EN` undefined: no comparator or max registers are built, and `max_channel` is tied to 0.

## Structure
- Package `adc_disp_pkg` holds:
  - `ADC_W`=12, `BCD_W`=16, `SHIFT_CNT`=12;
  - the FSM state enum `seq_state_t`.
- Sub-module `bcd_shift_converter`:
  - ports `clk`, `reset`, `start`, `bin[11:0]` → `bcd[15:0]`, `done`;
  - iterative, one shift per cycle, 4-bit shift counter.
- The top level owns the capture registers, FSM, dwell counter and max tracker.

## Test plan
- After reset, `sample[0]`=4095 and `enable`=1 → `bcd_valid` on cycle 13 after LOAD, with `bcd_value`=16'h4095 and `cur_channel`=0.
- `NUM_CH`=4, `DWELL_CYCLES`=4, samples 0, 9, 10, 999 → pulses 18 cycles apart with values 16'h0000, 16'h0009, 16'h0010, 16'h0999; `cur_channel` goes 0..3, then back to 0.
- `adc_valid[1]` with 1234 in the same cycle as LOAD of channel 1 (old value 7) → shows 16'h0007, then 16'h1234 on the next round.
- `enable` dropped on SHIFT cycle 5 → `bcd_valid` still pulses on cycle 13, then `busy`=0 and IDLE. `enable` dropped in DWELL → IDLE, and re-enable reshows the same channel.
- `reset` pulsed on SHIFT cycle 6 → `bcd_value`=0 and `busy`=0 immediately, and no `bcd_valid` pulse. After release with `enable`=1, conversion restarts at channel 0.
- With the macro, samples 100, 3000, 3000, 5 → `max_channel`=1 after channel 3's DONE; without the macro, `max_channel`=0 throughout.
